// File: rtl/l2_bank_req_adapter.sv
// l2_bank_req_adapter: TCDM req/gnt/resp port to single-cycle SRAM macro strobes,
// with a post-reset zero sweep and out-of-range error responses.
module l2_bank_req_adapter #(
    parameter int ADDR_W  = 15,
    parameter int DEPTH   = 29184,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              scan_en_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       add_i,
    input  logic              wen_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              r_valid_o,
    output logic [31:0]       r_rdata_o,
    output logic              r_opc_o,
    output logic              init_done_o,
    output logic              CEN,
    output logic              WEN,
    output logic [3:0]        BEN,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       D,
    input  logic [31:0]       Q
);
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

    logic              state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              ropc_q, ropc_d;
    logic              rread_q, rread_d;
    logic [ADDR_W-1:0] idx;
    logic              in_range, active, init_wr, run_acc;
    logic              addr_unused;

    assign idx         = add_i[ADDR_W+1:2];
    assign addr_unused = ^{add_i[31:ADDR_W+2], add_i[1:0]};
    assign in_range    = idx < DEPTH_W;

    // Strobes are gated by RST so the macro sees an idle port while reset is held.
    always_comb begin
        active   = !RST && !scan_en_i;
        gnt_o    = (state_q == ST_RUN) && req_i && active;
        init_wr  = (state_q == ST_INIT) && active;
        run_acc  = gnt_o && in_range;
        CEN      = !(init_wr || run_acc);
        WEN      = run_acc ? wen_i : !init_wr;
        BEN      = run_acc ? ~be_i : (init_wr ? 4'h0 : 4'hF);
        A        = run_acc ? idx : ((state_q == ST_INIT) ? cnt_q : '0);
        D        = run_acc ? wdata_i : '0;
        state_d  = (init_wr && cnt_q == LAST_W) ? ST_RUN : state_q;
        cnt_d    = init_wr ? cnt_q + ADDR_W'(1) : cnt_q;
        rvalid_d = gnt_o;
        ropc_d   = gnt_o && !in_range;
        rread_d  = run_acc && wen_i;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            ropc_q   <= 1'b0;
            rread_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            ropc_q   <= ropc_d;
            rread_q  <= rread_d;
        end
    end

    assign r_valid_o   = rvalid_q;
    assign r_opc_o     = ropc_q;
    assign r_rdata_o   = rread_q ? Q : '0;
    assign init_done_o = (state_q == ST_RUN);
endmodule

// File: tb/tb_l2_bank_req_adapter.sv
// tb_l2_bank_req_adapter: randomized check of the bank adapter against a word-level
// memory model, with a simple SRAM macro model providing Q.
module tb_l2_bank_req_adapter;
    localparam int DEPTH = 29184;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        scan_en_i = 1'b0;
    logic        req_i = 1'b1;
    logic [31:0] add_i = 32'h10;
    logic        wen_i = 1'b1;
    logic [3:0]  be_i = 4'hF;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o, r_valid_o, r_opc_o, init_done_o, CEN, WEN;
    logic [31:0] r_rdata_o, D, Q;
    logic [3:0]  BEN;
    logic [14:0] A;

    int n_chk = 0;
    int n_pass = 0;
    logic        exp_v = 1'b0;
    logic        exp_opc = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] ref_mem [int];
    logic [31:0] bank [DEPTH];
    logic [31:0] q_r = 32'h0;

    l2_bank_req_adapter dut (
        .CLK(CLK), .RST(RST), .scan_en_i(scan_en_i), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i),
        .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .init_done_o(init_done_o), .CEN(CEN), .WEN(WEN), .BEN(BEN), .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    assign Q = q_r;
    always @(posedge CLK) begin
        if (!CEN && int'(A) < DEPTH) begin
            if (!WEN) begin
                for (int b = 0; b < 4; b++)
                    if (!BEN[b]) bank[A][b*8 +: 8] <= D[b*8 +: 8];
            end else begin
                q_r <= bank[A];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    task automatic wr(input int i, input logic [3:0] b, input logic [31:0] wd);
        logic [31:0] v;
        v = rd(i);
        for (int k = 0; k < 4; k++)
            if (b[k]) v[k*8 +: 8] = wd[k*8 +: 8];
        ref_mem[i] = v;
    endtask

    task automatic cyc(input logic rq, input logic [31:0] ad, input logic we,
                       input logic [3:0] b, input logic [31:0] wd, input logic sc);
        logic [14:0] i;
        logic g, inr;
        @(negedge CLK);
        req_i = rq; add_i = ad; wen_i = we; be_i = b; wdata_i = wd; scan_en_i = sc;
        #1;
        chk("resp", {r_valid_o, r_opc_o, r_rdata_o}, {exp_v, exp_opc, exp_rd});
        i = ad[16:2];
        g = rq && !sc;
        inr = int'(i) < DEPTH;
        if (g && inr)
            chk("acc", {init_done_o, gnt_o, CEN, WEN, BEN, A, D}, {1'b1, 1'b1, 1'b0, we, ~b, i, wd});
        else
            chk("noacc", {init_done_o, gnt_o, CEN}, {1'b1, g, 1'b1});
        exp_v = g;
        exp_opc = g && !inr;
        exp_rd = (g && inr && we) ? rd(int'(i)) : 32'h0;
        if (g && inr && !we) wr(int'(i), b, wd);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [14:0] i;
        int m;
        m = $urandom_range(0, 3);
        i = (m == 0) ? 15'($urandom_range(0, 15)) :
            (m == 1) ? 15'($urandom_range(28668, 28675)) :
            (m == 2) ? 15'($urandom_range(29176, 29191)) : 15'($urandom_range(29184, 32767));
        return {15'($urandom), i, 2'($urandom)};
    endfunction

    initial begin
        int c;
        int sw;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_bank", {CEN, WEN, BEN, A, D, gnt_o}, {1'b1, 1'b1, 4'hF, 15'h0, 32'h0, 1'b0});
        chk("rst_resp", {r_valid_o, r_opc_o, r_rdata_o, init_done_o}, {1'b0, 1'b0, 32'h0, 1'b0});

        c = 0;
        sw = 0;
        while (sw < DEPTH && c < DEPTH + 100) begin
            @(negedge CLK);
            if (c == 0) RST = 1'b0;
            scan_en_i = (c >= 100 && c < 110);
            #1;
            if (scan_en_i) begin
                chk("pause", {CEN, A, gnt_o, init_done_o, r_valid_o}, {1'b1, 15'(sw), 3'b0});
            end else begin
                chk("sweep", {CEN, WEN, BEN, A, D, gnt_o, init_done_o, r_valid_o},
                    {1'b0, 1'b0, 4'h0, 15'(sw), 32'h0, 3'b0});
                sw++;
            end
            c++;
        end
        chk("sweep_len", 64'(c), 64'(DEPTH + 10));

        cyc(1'b1, 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 4'b0101, 32'hDEADBEEF, 1'b0);
        cyc(1'b1, 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0);
        chk("be_merge", r_rdata_o, 32'h00AD00EF);

        cyc(1'b1, 32'(28671 * 4), 1'b0, 4'hF, 32'h11110001, 1'b0);
        cyc(1'b1, 32'(28672 * 4), 1'b0, 4'hF, 32'h22220002, 1'b0);
        cyc(1'b1, 32'(29183 * 4), 1'b0, 4'hF, 32'h33330003, 1'b0);
        cyc(1'b1, 32'(28671 * 4), 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 32'(28672 * 4), 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 32'(29183 * 4), 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 32'h1C800, 1'b1, 4'hF, 32'h0, 1'b0);
        chk("last_word", r_rdata_o, 32'h33330003);
        cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0);
        chk("oor_opc", {r_valid_o, r_opc_o, r_rdata_o}, {1'b1, 1'b1, 32'h0});

        cyc(1'b1, 32'h44, 1'b0, 4'h0, 32'hFFFFFFFF, 1'b0);
        cyc(1'b1, 32'hFFFE0044, 1'b1, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 32'h44, 1'b1, 4'hF, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 3) != 0, rnd_addr(), 1'($urandom), 4'($urandom),
                $urandom, $urandom_range(0, 7) == 0);
        cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0);

        cyc(1'b1, 32'h20, 1'b1, 4'hF, 32'h0, 1'b0);
        @(posedge CLK);
        #2;
        chk("pre_rst_valid", r_valid_o, 1'b1);
        RST = 1'b1;
        #1;
        chk("async_rst", {r_valid_o, init_done_o, CEN, gnt_o}, {1'b0, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (k == 0) RST = 1'b0;
            #1;
            chk("resweep", {CEN, A, gnt_o, r_valid_o}, {1'b0, 15'(k), 2'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/l2_bank_req_adapter.md
Name: l2_bank_req_adapter

Overview:
- Front-end stage that sits directly upstream of one L2 SRAM bank (28672+512 word composite, macro-style CEN/WEN/BEN/A/D/Q port).
- Converts a PULP TCDM-style request/grant/response port into single-cycle macro strobes.
- After reset, runs a zero-initialisation sweep across the whole bank.
- Flags out-of-range word addresses and returns a one-cycle-latency response stream.

Parameters:
- ADDR_W, 15, word address width driven to the bank.
- DEPTH, 29184, number of implemented words; indices >= DEPTH are out of range.
- INIT_EN, 1, 1 = run the zero sweep after reset; 0 = go straight to RUN.

Ports:
- CLK  in  1  clock (bank clock, same edge).
- RST  in  1  asynchronous active-high reset.
- scan_en_i  in  1  scan mode; blocks all bank access.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- add_i  in  32  byte address; word index = add_i[ADDR_W+1:2].
- wen_i  in  1  0 = write, 1 = read.
- be_i  in  4  byte enables, active high.
- wdata_i  in  32  write data.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  32  read data.
- r_opc_o  out  1  1 = access error (out of range).
- init_done_o  out  1  sweep complete; port usable.
- CEN  out  1  bank chip enable, active low.
- WEN  out  1  bank write enable, active low.
- BEN  out  4  bank byte enable, active low.
- A  out  ADDR_W  bank word address.
- D  out  32  bank write data.
- Q  in  32  bank read data, valid the cycle after a CEN=0 read.

Behaviour:
- Clock/reset: one clock, CLK. Reset RST is asynchronous and active high.
- Reset values:
  - state=INIT if INIT_EN else RUN; init counter=0.
  - gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0.
  - CEN=1, WEN=1, BEN=4'hF, A=0, D=0.
  - init_done_o = !INIT_EN.
- States: INIT, RUN.
- INIT:
  - Each cycle with scan_en_i=0: CEN=0, WEN=0, BEN=0, A=cnt, D=0, then cnt++.
  - When a write with cnt==DEPTH-1 issues, next state is RUN and init_done_o goes 1 on the next cycle.
  - scan_en_i=1 pauses the sweep: CEN=1, cnt held.
  - gnt_o=0 throughout INIT; requests are held off, not dropped. No responses are generated.
- RUN:
  - gnt_o = req_i & !scan_en_i (combinational).
  - On a grant with in-range index: CEN=0, WEN=wen_i, BEN=~be_i, A=index, D=wdata_i, all combinational in the grant cycle.
  - Out-of-range grant (index >= DEPTH): CEN=1 (no bank access). A one-shot error flag is registered.
  - No grant: CEN=1; WEN/BEN/D are don't-care.
- Response, exactly one per grant, in the cycle after it:
  - r_valid_o=1.
  - In-range read: r_rdata_o = Q (passthrough; the bank mux select is already registered), r_opc_o=0.
  - Write: r_rdata_o=0, r_opc_o=0.
  - Out-of-range read or write: r_rdata_o=0, r_opc_o=1.
  - r_valid_o is 0 in every cycle not following a grant.
- Throughput: back-to-back grants every cycle. No response backpressure; the consumer must sink r_valid every cycle.
- be_i=0 write: granted, CEN=0 with BEN=F, response r_opc_o=0.
- scan_en_i rising with a response pending: the pending response still completes next cycle. New grants are blocked.
- RST mid-sweep or mid-request: everything returns to reset values immediately. The sweep restarts from 0, and the outstanding response is discarded.
- Width rule: index compare is unsigned on ADDR_W bits. add_i bits above ADDR_W+1 are ignored (alias).

Test Plan:
- Reset, INIT_EN=1, req_i=1 held -> gnt_o=0 for 29184 cycles with A sweeping 0..29183, D=0, BEN=0. init_done_o=1 on cycle 29185, and the first grant occurs in that same cycle.
- Sweep with scan_en_i=1 for cycles 100-109 -> A frozen at 100 and CEN=1 for those cycles. Completion is delayed by exactly 10 cycles.
- RUN: write 0xDEADBEEF to add_i=0x10 with be=4'b0101, then read 0x10 -> write has CEN=0, WEN=0, BEN=4'b1010. Read response next cycle is r_rdata_o=0x00AD00EF with r_opc_o=0.
- Back-to-back reads of word indices 28671, 28672, 29183 (cut 6, the 512-word cut, its last word) -> three consecutive r_valid_o cycles, each carrying the correct bank data.
- Read add_i=0x1C800 (index 29184) -> gnt_o=1, CEN=1. Next cycle: r_valid_o=1, r_opc_o=1, r_rdata_o=0.
- RST asserted asynchronously between a read grant and its response -> r_valid_o=0 immediately. After release, state=INIT and A restarts at 0.
